// File: rtl/noc_bench_sequencer_pkg.sv
// Shared types and elaboration helpers for the NoC experiment run controller.
package noc_bench_pkg;

   localparam int CNT_W_DEF = 32;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARM,
      S_WAIT_LOW,
      S_INJECT,
      S_DRAIN,
      S_DONE
   } state_t;

   // Total packets expected across the mesh; callers truncate to their counter width.
   function automatic logic [63:0] calc_exp(input int x, input int y, input int num_packets);
      return longint'(x) * longint'(y) * longint'(num_packets);
   endfunction

endpackage

// File: rtl/noc_bench_sequencer_if.sv
// Control/status bundle between the bench top level and the run controller.
interface noc_bench_sequencer_if #(
   parameter int X     = 3,
   parameter int Y     = 5,
   parameter int CNT_W = 32
);
   localparam int N = X * Y;

   logic               go;
   logic               gen_done;
   logic [CNT_W*N-1:0] receive_count;
   logic               start;
   logic [N-1:0]       enable_send;
   logic               busy;
   logic               finished;
   logic               timed_out;
   logic               over_rx;
   logic [CNT_W-1:0]   cycle_count;
   logic [CNT_W-1:0]   rx_total;

   modport master (
      output go, gen_done, receive_count,
      input  start, enable_send, busy, finished, timed_out, over_rx, cycle_count, rx_total
   );

   modport slave (
      input  go, gen_done, receive_count,
      output start, enable_send, busy, finished, timed_out, over_rx, cycle_count, rx_total
   );
endinterface

// File: rtl/noc_bench_sequencer_rx_count_scanner.sv
// Serial adder over the per-PE receive counters: one PE per cycle, new rx_total every N cycles
// with a one-cycle snap_valid pulse alongside it; free-running, never stalls.
module rx_count_scanner #(
   parameter int N     = 15,
   parameter int CNT_W = 32
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic [CNT_W*N-1:0] receive_count,
   output logic [CNT_W-1:0]   rx_total,
   output logic               snap_valid
);
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
   localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

   logic [IDX_W-1:0] idx;
   logic [CNT_W-1:0] acc;
   logic [CNT_W-1:0] cur;

   always_comb begin
      cur = receive_count[int'(idx)*CNT_W +: CNT_W];
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         idx        <= '0;
         acc        <= '0;
         rx_total   <= '0;
         snap_valid <= 1'b0;
      end else if (idx == LAST) begin
         rx_total   <= acc + cur;
         acc        <= '0;
         idx        <= '0;
         snap_valid <= 1'b1;
      end else begin
         acc        <= acc + cur;
         idx        <= idx + IDX_W'(1);
         snap_valid <= 1'b0;
      end
   end
endmodule

// File: rtl/noc_bench_sequencer.sv
// Run controller for one NoC traffic experiment: arms generators, waits for done, drains, times the run.
// Optional STAGGER_START_EN ramps enable_send one PE per cycle instead of all at once.
module noc_bench_sequencer
   import noc_bench_pkg::*;
#(
   parameter int X             = 3,
   parameter int Y             = 5,
   parameter int NUM_PACKETS   = 1000,
   parameter int DRAIN_TIMEOUT = 100000,
   parameter int CNT_W         = CNT_W_DEF
) (
   input  logic                  clk,
   input  logic                  rstn,
   noc_bench_sequencer_if.slave  bus
);
   localparam int N = X * Y;
   localparam logic [63:0]      EXP_FULL = calc_exp(X, Y, NUM_PACKETS);
   localparam logic [CNT_W-1:0] EXP      = EXP_FULL[CNT_W-1:0];
   localparam int DW = $clog2(DRAIN_TIMEOUT + 1);
   localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_TIMEOUT - 1);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] rx_total;
   logic             snap_valid;
   logic [DW-1:0]    drain_cnt;
   logic             start_q;
   logic [N-1:0]     en_q;
   logic             timed_q, over_q;
   logic [CNT_W-1:0] cyc_q;
   logic             busy, arm_entry, completion, timeout;

   rx_count_scanner #(.N(N), .CNT_W(CNT_W)) u_scan (
      .clk           (clk),
      .rstn          (rstn),
      .receive_count (bus.receive_count),
      .rx_total      (rx_total),
      .snap_valid    (snap_valid)
   );

   always_comb begin
      state_nxt  = state;
      completion = 1'b0;
      timeout    = 1'b0;
      case (state)
         S_IDLE, S_DONE: if (bus.go) state_nxt = S_ARM;
         S_ARM:          state_nxt = S_WAIT_LOW;
         S_WAIT_LOW:     if (!bus.gen_done) state_nxt = S_INJECT;
         S_INJECT:       if (bus.gen_done) state_nxt = S_DRAIN;
         S_DRAIN: begin
            // A fresh snapshot reaching the target beats a simultaneous timeout.
            completion = snap_valid && (rx_total >= EXP);
            timeout    = !completion && (drain_cnt == DRAIN_LAST);
            if (completion || timeout) state_nxt = S_DONE;
         end
         default:        state_nxt = S_IDLE;
      endcase
   end

   assign busy      = (state == S_ARM) || (state == S_WAIT_LOW) ||
                      (state == S_INJECT) || (state == S_DRAIN);
   assign arm_entry = ((state == S_IDLE) || (state == S_DONE)) && bus.go;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state     <= S_IDLE;
         drain_cnt <= '0;
         start_q   <= 1'b0;
         en_q      <= '0;
         timed_q   <= 1'b0;
         over_q    <= 1'b0;
         cyc_q     <= '0;
      end else begin
         state <= state_nxt;

         if (arm_entry) begin
            cyc_q     <= '0;
            timed_q   <= 1'b0;
            over_q    <= 1'b0;
            drain_cnt <= '0;
         end else if (busy && (cyc_q != {CNT_W{1'b1}})) begin
            cyc_q <= cyc_q + CNT_W'(1);
         end

         if (state == S_DRAIN) drain_cnt <= drain_cnt + DW'(1);
         if (timeout) timed_q <= 1'b1;
         if (completion && (rx_total > EXP)) over_q <= 1'b1;

         if (state == S_ARM) begin
            start_q <= 1'b1;
`ifdef STAGGER_START_EN
            en_q    <= N'(1);
`else
            en_q    <= '1;
`endif
         end else if (state_nxt == S_DONE && state == S_DRAIN) begin
            start_q <= 1'b0;
            en_q    <= '0;
         end
`ifdef STAGGER_START_EN
         else if (start_q) begin
            en_q <= (en_q << 1) | N'(1);
         end
`endif
      end
   end

   assign bus.start       = start_q;
   assign bus.enable_send = en_q;
   assign bus.busy        = busy;
   assign bus.finished    = (state == S_DONE);
   assign bus.timed_out   = timed_q;
   assign bus.over_rx     = over_q;
   assign bus.cycle_count = cyc_q;
   assign bus.rx_total    = rx_total;
endmodule

// File: tb/tb_noc_bench_sequencer.sv
// Randomized scenario bench for noc_bench_sequencer against a run-level outcome model.
module tb_noc_bench_sequencer;
   localparam int X     = 3;
   localparam int Y     = 5;
   localparam int N     = X * Y;
   localparam int NP    = 4;
   localparam int DT    = 50;
   localparam int CNT_W = 32;
   localparam int EXP   = N * NP;

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   noc_bench_sequencer_if #(.X(X), .Y(Y), .CNT_W(CNT_W)) bus ();

   noc_bench_sequencer #(
      .X(X), .Y(Y), .NUM_PACKETS(NP), .DRAIN_TIMEOUT(DT), .CNT_W(CNT_W)
   ) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   int checks   = 0;
   int failures = 0;
   int busy_seen;
   int rc [N];

   function automatic logic [CNT_W*N-1:0] pack_rc();
      logic [CNT_W*N-1:0] v;
      v = '0;
      for (int i = 0; i < N; i++) v[i*CNT_W +: CNT_W] = CNT_W'(rc[i]);
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
      if (bus.busy) busy_seen++;
   endtask

   // Spread 'total' packets randomly over the PEs, then let the scanner see them twice over.
   task automatic set_sum(input int total);
      for (int i = 0; i < N; i++) rc[i] = 0;
      for (int k = 0; k < total; k++) rc[$urandom_range(N-1, 0)]++;
      bus.receive_count = pack_rc();
      repeat (2*N) tick();
   endtask

   task automatic pulse_go();
      bus.go = 1'b1;
      tick();
      bus.go = 1'b0;
   endtask

   task automatic wait_finished(input int budget, output int n);
      n = 0;
      while (!bus.finished && n < budget) begin
         tick();
         n++;
      end
   endtask

   task automatic test_reset();
      int bad;
      rstn = 1'b0; bus.go = 1'b0; bus.gen_done = 1'b0;
      for (int i = 0; i < N; i++) rc[i] = 0;
      bus.receive_count = pack_rc();
      repeat (5) tick();
      checks++; if (bus.start !== 1'b0) begin failures++; $display("FAIL reset_start got=%0b exp=0", bus.start); end
      checks++; if (bus.enable_send !== '0) begin failures++; $display("FAIL reset_enable_send got=%0h exp=0", bus.enable_send); end
      checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", bus.busy); end
      checks++; if (bus.finished !== 1'b0) begin failures++; $display("FAIL reset_finished got=%0b exp=0", bus.finished); end
      checks++; if (bus.timed_out !== 1'b0) begin failures++; $display("FAIL reset_timed_out got=%0b exp=0", bus.timed_out); end
      checks++; if (bus.over_rx !== 1'b0) begin failures++; $display("FAIL reset_over_rx got=%0b exp=0", bus.over_rx); end
      checks++; if (bus.cycle_count !== '0) begin failures++; $display("FAIL reset_cycle_count got=%0d exp=0", bus.cycle_count); end
      checks++; if (bus.rx_total !== '0) begin failures++; $display("FAIL reset_rx_total got=%0d exp=0", bus.rx_total); end
      rstn = 1'b1;
      bad = 0;
      repeat (20) begin
         tick();
         if (bus.start !== 1'b0 || bus.enable_send !== '0 || bus.busy !== 1'b0 || bus.finished !== 1'b0 ||
             bus.timed_out !== 1'b0 || bus.over_rx !== 1'b0 || bus.cycle_count !== '0 || bus.rx_total !== '0) bad++;
      end
      checks++; if (bad !== 0) begin failures++; $display("FAIL idle_quiet nonzero_cycles=%0d exp=0", bad); end
   endtask

   task automatic test_normal_run();
      int t, t_rise, t_full, t_fin, sum, inc, k, bound;
      logic [N-1:0] exp_mask;
      for (int i = 0; i < N; i++) rc[i] = 0;
      bus.receive_count = pack_rc();
      bus.gen_done = 1'b1;
      repeat (2*N) tick();
      busy_seen = 0;
      pulse_go();
      checks++; if (bus.start !== 1'b0) begin failures++; $display("FAIL arm_start got=%0b exp=0", bus.start); end
      tick();
`ifdef STAGGER_START_EN
      exp_mask = N'(1);
`else
      exp_mask = '1;
`endif
      checks++; if (bus.start !== 1'b1) begin failures++; $display("FAIL start_after_arm got=%0b exp=1", bus.start); end
      checks++; if (bus.enable_send !== exp_mask) begin failures++; $display("FAIL enable_after_arm got=%0h exp=%0h", bus.enable_send, exp_mask); end
      t = 2; sum = 0; t_full = -1; t_fin = -1;
      t_rise = $urandom_range(35, 20);
      bus.gen_done = 1'b0;
      while (t_fin < 0 && t < 200) begin
         if (t >= 3 && sum < EXP) begin
            inc = $urandom_range(4, 2);
            for (int j = 0; j < inc && sum < EXP; j++) begin
               do k = $urandom_range(N-1, 0); while (rc[k] >= NP);
               rc[k]++; sum++;
            end
            bus.receive_count = pack_rc();
            if (sum == EXP) t_full = t;
         end
         if (t == t_rise) bus.gen_done = 1'b1;
         tick();
         t++;
         if (bus.finished) t_fin = t;
      end
      bound = ((t_full > t_rise) ? t_full : t_rise) + 2*N + 1;
      checks++; if (t_fin < 0) begin failures++; $display("FAIL normal_finish got=none exp=finished"); end
      checks++; if (t_fin < t_rise + 2 || t_fin > bound) begin failures++; $display("FAIL normal_latency got=%0d exp=%0d..%0d", t_fin, t_rise+2, bound); end
      checks++; if (bus.rx_total !== CNT_W'(EXP)) begin failures++; $display("FAIL normal_rx_total got=%0d exp=%0d", bus.rx_total, EXP); end
      checks++; if (bus.timed_out !== 1'b0 || bus.over_rx !== 1'b0) begin failures++; $display("FAIL normal_flags got=%0b%0b exp=00", bus.timed_out, bus.over_rx); end
      checks++; if (bus.cycle_count !== CNT_W'(busy_seen)) begin failures++; $display("FAIL normal_cycle_count got=%0d exp=%0d", bus.cycle_count, busy_seen); end
      checks++; if (bus.start !== 1'b0 || bus.enable_send !== '0) begin failures++; $display("FAIL done_outputs got=%0b/%0h exp=0/0", bus.start, bus.enable_send); end
   endtask

   // One complete run with a random per-PE split of 'total'; outcome predicted from the total alone.
   task automatic run_and_check(input string tag, input int total, input bit go_in_drain);
      int n, pre, k;
      bit exp_to, exp_over;
      exp_to   = (total < EXP);
      exp_over = (total > EXP);
      set_sum(total);
      busy_seen = 0;
      pulse_go();
      bus.gen_done = 1'b0;
      repeat (2 + $urandom_range(4, 0)) tick();
      bus.gen_done = 1'b1;
      pre = 0;
      if (go_in_drain) begin
         k = exp_to ? $urandom_range(20, 5) : 2;
         for (int i = 0; i < k && !bus.finished; i++) begin
            bus.go = (i == k - 1);
            tick();
            pre++;
         end
         bus.go = 1'b0;
      end
      wait_finished(DT + 20, n);
      n += pre;
      if (exp_to) begin
         checks++; if (n != DT + 1) begin failures++; $display("FAIL %s_timeout_cycles got=%0d exp=%0d", tag, n, DT + 1); end
      end else begin
         checks++; if (n < 2 || n > N + 1) begin failures++; $display("FAIL %s_done_cycles got=%0d exp=2..%0d", tag, n, N + 1); end
      end
      checks++; if (bus.finished !== 1'b1) begin failures++; $display("FAIL %s_finished got=%0b exp=1", tag, bus.finished); end
      checks++; if (bus.timed_out !== exp_to) begin failures++; $display("FAIL %s_timed_out got=%0b exp=%0b", tag, bus.timed_out, exp_to); end
      checks++; if (bus.over_rx !== exp_over) begin failures++; $display("FAIL %s_over_rx got=%0b exp=%0b", tag, bus.over_rx, exp_over); end
      checks++; if (bus.rx_total !== CNT_W'(total)) begin failures++; $display("FAIL %s_rx_total got=%0d exp=%0d", tag, bus.rx_total, total); end
      checks++; if (bus.cycle_count !== CNT_W'(busy_seen)) begin failures++; $display("FAIL %s_cycle_count got=%0d exp=%0d", tag, bus.cycle_count, busy_seen); end
   endtask

   task automatic test_timeout();
      run_and_check("timeout", EXP - 1, 1'b1);
   endtask

   task automatic test_over_rx();
      run_and_check("over_rx", EXP + $urandom_range(5, 1), 1'b0);
   endtask

   task automatic test_mid_reset();
      int n;
      set_sum(EXP);
      busy_seen = 0;
      pulse_go();
      bus.gen_done = 1'b0;
      repeat (3 + $urandom_range(5, 0)) tick();
      rstn = 1'b0;
      tick();
      checks++; if (bus.start !== 1'b0 || bus.enable_send !== '0) begin failures++; $display("FAIL midrst_drive got=%0b/%0h exp=0/0", bus.start, bus.enable_send); end
      checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%0b exp=0", bus.busy); end
      checks++; if (bus.cycle_count !== '0 || bus.rx_total !== '0) begin failures++; $display("FAIL midrst_counts got=%0d/%0d exp=0/0", bus.cycle_count, bus.rx_total); end
      rstn = 1'b1;
      repeat (3) tick();
      busy_seen = 0;
      pulse_go();
      checks++; if (bus.cycle_count !== '0 || bus.busy !== 1'b1) begin failures++; $display("FAIL midrst_rearm got=%0d/%0b exp=0/1", bus.cycle_count, bus.busy); end
      repeat (2) tick();
      bus.gen_done = 1'b1;
      wait_finished(DT + 20, n);
      checks++; if (bus.finished !== 1'b1 || bus.timed_out !== 1'b0) begin failures++; $display("FAIL midrst_run got=%0b/%0b exp=1/0", bus.finished, bus.timed_out); end
      checks++; if (bus.cycle_count !== CNT_W'(busy_seen)) begin failures++; $display("FAIL midrst_cycle_count got=%0d exp=%0d", bus.cycle_count, busy_seen); end
   endtask

   task automatic test_stale_done();
      int bad, h, n;
      // Previous run left finished=1, gen_done=1 and counters at EXP.
      busy_seen = 0;
      pulse_go();
      h = $urandom_range(20, 8);
      bad = 0;
      repeat (h) begin
         tick();
         if (bus.busy !== 1'b1 || bus.finished !== 1'b0) bad++;
      end
      checks++; if (bad !== 0) begin failures++; $display("FAIL stale_hold bad_cycles=%0d exp=0", bad); end
      bus.gen_done = 1'b0;
      repeat (2) tick();
      bus.gen_done = 1'b1;
      wait_finished(DT + 20, n);
      checks++; if (n < 2 || n > N + 1) begin failures++; $display("FAIL stale_done_cycles got=%0d exp=2..%0d", n, N + 1); end
      checks++; if (bus.cycle_count !== CNT_W'(busy_seen)) begin failures++; $display("FAIL stale_cycle_count got=%0d exp=%0d", bus.cycle_count, busy_seen); end
   endtask

   task automatic test_back_to_back();
      int total;
      for (int r = 0; r < 6; r++) begin
         total = EXP + $urandom_range(6, 0) - 3;
         run_and_check("b2b", total, r[0]);
      end
   endtask

   initial begin
      bus.go = 1'b0;
      bus.gen_done = 1'b0;
      bus.receive_count = '0;
      busy_seen = 0;
      test_reset();
      test_normal_run();
      test_timeout();
      test_over_rx();
      test_mid_reset();
      test_stale_done();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/noc_bench_sequencer.md
Name: noc_bench_sequencer

Overview:
- Run controller for one NoC traffic experiment.
- Sits between the bench top level and the traffic-generator array, next to openNocTop.
- Sequences start/enableSend into the generators and waits for the generators' done.
- Sums the per-PE receive counters, detects drain completion or timeout, and reports the run's cycle count for throughput/efficiency calculation.

Parameters:
- X, 3, mesh columns.
- Y, 5, mesh rows.
- NUM_PACKETS, 1000, packets each PE injects.
- DRAIN_TIMEOUT, 100000, maximum DRAIN cycles before abort.
- CNT_W, 32, width of cycle_count, rx_total and each receive counter.

Ports:
- clk  in  1  system clock.
- rstn  in  1  reset; synchronous, active-low.
- go  in  1  single-cycle pulse that starts a run; accepted only in IDLE or DONE.
- gen_done  in  1  generator-array done flag.
- receive_count  in  CNT_W*X*Y  per-PE received-packet counters; PE i occupies bits [i*CNT_W +: CNT_W].
- start  out  1  run enable to the generators.
- enable_send  out  X*Y  per-PE send enable.
- busy  out  1  high in ARM, WAIT_LOW, INJECT and DRAIN.
- finished  out  1  high in DONE.
- timed_out  out  1  DRAIN ended on timeout; sticky until the next go.
- over_rx  out  1  rx_total snapshot exceeded expected; sticky until the next go.
- cycle_count  out  CNT_W  cycles from ARM entry to DONE entry.
- rx_total  out  CNT_W  latest sum snapshot of receive_count.

Behaviour:
- N = X*Y. EXP = N*NUM_PACKETS, computed at elaboration at CNT_W width.
- Reset (rstn=0 at a clk edge): state=IDLE; all outputs 0; scan index, accumulator and drain counter cleared. This applies mid-run too: start and enable_send drop on the next edge.
- FSM states: IDLE, ARM, WAIT_LOW, INJECT, DRAIN, DONE.
- IDLE: go -> ARM.
- DONE: go -> ARM. Entering ARM clears cycle_count, timed_out, over_rx and the drain counter.
- ARM (exactly 1 cycle): registers start=1 and enable_send={N{1}}, visible from the following cycle. Next state WAIT_LOW.
- WAIT_LOW: stays until gen_done=0. This rejects a stale done left over from a previous run. Then -> INJECT.
- INJECT: stays until gen_done=1, then -> DRAIN.
- DRAIN:
  - Increments the drain counter each cycle.
  - Completion: a snapshot update with value >= EXP -> DONE. If the value is > EXP, also set over_rx.
  - Timeout: drain counter == DRAIN_TIMEOUT-1 with no completion -> DONE and set timed_out.
  - If completion and timeout occur in the same cycle, completion wins and timed_out stays 0.
- Entering DONE: start=0 and enable_send=0 on the same edge.
- cycle_count:
  - Increments every cycle while busy, including the ARM cycle.
  - Frozen in DONE and IDLE.
  - Saturates at all-ones; it never wraps.
- Serial receive-count scan, free-running in every state except reset:
  - Index s runs 0..N-1 and wraps to 0.
  - Each cycle: acc += receive_count[s].
  - When s==N-1: rx_total <= acc + receive_count[N-1], and acc <= 0.
  - Snapshot period is N cycles. Worst-case detection latency from the last packet arrival is 2N+1 cycles.
  - Addition is modulo 2^CNT_W.
- go while busy is ignored.

Optional Feature:
- Macro: STAGGER_START_EN.
- When defined: after ARM, enable_send turns on one bit per cycle, bit 0 first, so the whole mask is set N cycles after ARM. This avoids simultaneous injection bursts. WAIT_LOW still checks gen_done from the cycle after ARM. Reset or DONE clears the mask at once.
- When undefined: the full mask is asserted in the cycle after ARM, as described above.

Decomposition:
- Shared package noc_bench_pkg holds:
  - state enum for the six states;
  - the EXP computation function;
  - the CNT_W default.
- Sub-module rx_count_scanner holds the serial index, accumulator and snapshot register. It exposes rx_total plus a one-cycle snap_valid pulse.
- All other logic stays in the top FSM.

Test Plan:
- Reset/idle: hold rstn=0 for 5 cycles -> all outputs 0. Release with go=0 for 20 cycles -> state stays IDLE and outputs stay 0.
- Normal run (X=3, Y=5, NUM_PACKETS=4, EXP=60):
  - Stimulus: pulse go; gen_done=1 initially, 0 at cycle 3, 1 at cycle 40. Counters ramp to 4 each by cycle 70.
  - Required: start=1 from cycle 2; finished=1 within 31 cycles of counters reaching 60; rx_total=60; timed_out=0; cycle_count equals the number of busy cycles.
- Timeout (DRAIN_TIMEOUT=50): counters stuck at a sum of 59 -> DONE exactly 50 cycles after DRAIN entry, timed_out=1, rx_total=59.
- Over-receive: counters sum to 61 -> DONE, over_rx=1.
- Mid-run reset: assert rstn=0 while in INJECT -> the next edge shows start=0, enable_send=0, busy=0. A go after release runs a clean run with cycle_count restarted from 0.
- Re-run and stale done: in DONE with gen_done held at 1, pulse go -> FSM waits in WAIT_LOW until gen_done falls. Also, a go asserted during DRAIN has no effect.
